// File: rtl/modadd_sched.sv
// Round-robin scheduler in front of a shared fixed-latency modular adder, with in-order response FIFO
// and drain-then-update of the modulus. Define MODADD_SCHED_STATS_EN to add the op_cnt issue counter.
module modadd_sched #(
    parameter int N     = 7,
    parameter int NREQ  = 4,
    parameter int LAT   = 2,
    parameter int K_RST = 0
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic [NREQ-1:0]                         req_valid,
    output logic [NREQ-1:0]                         req_ready,
    input  logic [NREQ*N-1:0]                       req_a,
    input  logic [NREQ*N-1:0]                       req_b,
    output logic                                    add_valid,
    output logic [N-1:0]                            add_a,
    output logic [N-1:0]                            add_b,
    output logic [N-1:0]                            add_k,
    input  logic [N-1:0]                            add_sum,
    output logic                                    rsp_valid,
    output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] rsp_id,
    output logic [N-1:0]                            rsp_sum,
    input  logic                                    rsp_ready,
`ifdef MODADD_SCHED_STATS_EN
    output logic [15:0]                             op_cnt,
`endif
    input  logic                                    cfg_we,
    input  logic [N-1:0]                            cfg_k,
    output logic                                    cfg_busy
);
    localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int D    = LAT + 1;
    localparam int PW   = $clog2(D);
    localparam int CNTW = $clog2(D + 1);
    localparam int CW   = $clog2(LAT + 2) + 1;

    typedef enum logic {RUN, DRAIN} state_t;

    state_t          state, state_nxt;
    logic [N-1:0]    k, k_pend;
    logic [IDW-1:0]  ptr, gnt;
    logic            gnt_found;
    logic            issue, push, pop;
    logic [CW-1:0]   inflight, occ;

    logic [LAT:1]    vld_pipe;
    logic [IDW-1:0]  id_pipe [1:LAT];

    logic [IDW-1:0]  mem_id  [D];
    logic [N-1:0]    mem_sum [D];
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CNTW-1:0] fifo_cnt;

    // First valid requester after the last grant, wrapping.
    always_comb begin
        int idx;
        idx       = 0;
        gnt       = '0;
        gnt_found = 1'b0;
        for (int off = 1; off <= NREQ; off++) begin
            idx = (int'(ptr) + off) % NREQ;
            if (!gnt_found && req_valid[idx]) begin
                gnt       = IDW'(idx);
                gnt_found = 1'b1;
            end
        end
    end

    always_comb begin
        inflight = '0;
        for (int s = 1; s <= LAT; s++)
            inflight = inflight + CW'(vld_pipe[s]);
    end

    // A pop this cycle frees its slot at the same edge the new issue claims one,
    // so a streaming requester with rsp_ready held high keeps one issue per cycle.
    assign occ   = inflight + CW'(fifo_cnt) - CW'(pop);
    assign issue = !rst && (state == RUN) && !cfg_we && gnt_found && (occ < CW'(LAT + 1));

    always_comb begin
        req_ready = '0;
        add_a     = '0;
        add_b     = '0;
        if (issue) begin
            req_ready[gnt] = 1'b1;
            add_a          = req_a[int'(gnt)*N +: N];
            add_b          = req_b[int'(gnt)*N +: N];
        end
    end

    assign add_valid = issue;
    assign add_k     = k;
    assign cfg_busy  = !rst && (state == DRAIN);

    always_comb begin
        state_nxt = state;
        case (state)
            RUN:     if (cfg_we) state_nxt = DRAIN;
            DRAIN:   if (!cfg_we && inflight == '0) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= RUN;
            k      <= N'(K_RST);
            k_pend <= N'(K_RST);
            ptr    <= IDW'(NREQ - 1);
        end else begin
            state <= state_nxt;
            if (cfg_we)
                k_pend <= cfg_k;
            if (state == DRAIN && state_nxt == RUN)
                k <= k_pend;
            if (issue)
                ptr <= gnt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_pipe <= '0;
            for (int s = 1; s <= LAT; s++)
                id_pipe[s] <= '0;
        end else begin
            vld_pipe[1] <= issue;
            id_pipe[1]  <= gnt;
            for (int s = 2; s <= LAT; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                id_pipe[s]  <= id_pipe[s-1];
            end
        end
    end

    assign push      = vld_pipe[LAT];
    assign rsp_valid = !rst && (fifo_cnt != '0);
    assign pop       = rsp_valid && rsp_ready;
    assign rsp_id    = rsp_valid ? mem_id[rd_ptr]  : '0;
    assign rsp_sum   = rsp_valid ? mem_sum[rd_ptr] : '0;

    function automatic logic [PW-1:0] nxt_ptr(input logic [PW-1:0] p);
        return (p == PW'(D - 1)) ? '0 : p + 1'b1;
    endfunction

    always_ff @(posedge clk) begin
        if (push) begin
            mem_id[wr_ptr]  <= id_pipe[LAT];
            mem_sum[wr_ptr] <= add_sum;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            fifo_cnt <= '0;
        end else begin
            if (push) wr_ptr <= nxt_ptr(wr_ptr);
            if (pop)  rd_ptr <= nxt_ptr(rd_ptr);
            fifo_cnt <= fifo_cnt + CNTW'(push) - CNTW'(pop);
        end
    end

`ifdef MODADD_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst)        op_cnt <= '0;
        else if (issue) op_cnt <= op_cnt + 16'd1;
    end
`endif

endmodule

// File: tb/tb_modadd_sched.sv
// Bench for modadd_sched: stub adder, queue-based reference model checked every cycle,
// a vector table for the streaming round-robin case, and hand sequences for the corner cases.
module tb_modadd_sched;
    localparam int N = 7, NREQ = 4, LAT = 2, IDW = 2;

    logic                 clk, rst;
    logic [NREQ-1:0]      req_valid, req_ready;
    logic [NREQ*N-1:0]    req_a, req_b;
    logic                 add_valid;
    logic [N-1:0]         add_a, add_b, add_k, add_sum;
    logic                 rsp_valid, rsp_ready;
    logic [IDW-1:0]       rsp_id;
    logic [N-1:0]         rsp_sum;
    logic                 cfg_we, cfg_busy;
    logic [N-1:0]         cfg_k;
`ifdef MODADD_SCHED_STATS_EN
    logic [15:0]          op_cnt;
`endif

    logic [N-1:0] ra [NREQ];
    logic [N-1:0] rb [NREQ];

    modadd_sched #(.N(N), .NREQ(NREQ), .LAT(LAT), .K_RST(0)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
        .add_valid(add_valid), .add_a(add_a), .add_b(add_b), .add_k(add_k), .add_sum(add_sum),
        .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_sum(rsp_sum), .rsp_ready(rsp_ready),
`ifdef MODADD_SCHED_STATS_EN
        .op_cnt(op_cnt),
`endif
        .cfg_we(cfg_we), .cfg_k(cfg_k), .cfg_busy(cfg_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_a[i*N +: N] = ra[i];
            req_b[i*N +: N] = rb[i];
        end
    end

    function automatic int modf(input int a, input int b, input int kk);
        int s;
        s = a + b;
        if (kk == 0) return s % (1 << N);
        return s % kk;
    endfunction

    // Stub adder: result only meaningful exactly LAT cycles after add_valid, junk otherwise.
    logic         sv [1:LAT];
    logic [N-1:0] ss [1:LAT];
    logic [N-1:0] junk;
    always @(posedge clk) begin
        sv[1] <= add_valid;
        ss[1] <= N'(modf(int'(add_a), int'(add_b), int'(add_k)));
        for (int s = 2; s <= LAT; s++) begin
            sv[s] <= sv[s-1];
            ss[s] <= ss[s-1];
        end
        junk <= N'($urandom);
    end
    assign add_sum = (sv[LAT] === 1'b1) ? ss[LAT] : junk;

    // Reference model
    typedef struct { int id; int sum; int age; } tag_t;
    typedef struct { int id; int sum; } ent_t;
    tag_t infl[$];
    ent_t mfifo[$];
    int   m_drain, m_k, m_pend, m_ptr, m_known, n_issue;

    int checks, errors;
    logic [NREQ-1:0] o_ready;
    logic            o_rv, o_busy;
    logic [IDW-1:0]  o_id;
    logic [N-1:0]    o_sum, o_k;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic cycle();
        int pop, occ, g, e_rv, e_id, e_sum, pre_infl;
        tag_t nq[$];
        tag_t t;
        ent_t e;
        @(negedge clk);
        o_ready = req_ready; o_rv = rsp_valid; o_id = rsp_id; o_sum = rsp_sum;
        o_busy = cfg_busy; o_k = add_k;
        g = -1; pop = 0;
        if (rst) begin
            chk("rst_req_ready", req_ready, 0);
            chk("rst_add_valid", add_valid, 0);
            chk("rst_add_a", add_a, 0);
            chk("rst_add_b", add_b, 0);
            chk("rst_rsp_valid", rsp_valid, 0);
            chk("rst_rsp_id", rsp_id, 0);
            chk("rst_rsp_sum", rsp_sum, 0);
            chk("rst_cfg_busy", cfg_busy, 0);
        end else begin
            e_rv  = (mfifo.size() > 0) ? 1 : 0;
            e_id  = e_rv ? mfifo[0].id  : 0;
            e_sum = e_rv ? mfifo[0].sum : 0;
            pop   = (e_rv != 0 && rsp_ready) ? 1 : 0;
            occ   = infl.size() + mfifo.size() - pop;
            if (!m_drain && !cfg_we && occ < LAT + 1)
                for (int off = 1; off <= NREQ; off++) begin
                    int idx;
                    idx = (m_ptr + off) % NREQ;
                    if (g < 0 && req_valid[idx]) g = idx;
                end
            chk("req_ready", req_ready, (g >= 0) ? (64'd1 << g) : 64'd0);
            chk("add_valid", add_valid, (g >= 0) ? 1 : 0);
            chk("add_a", add_a, (g >= 0) ? ra[g] : 0);
            chk("add_b", add_b, (g >= 0) ? rb[g] : 0);
            chk("rsp_valid", rsp_valid, e_rv);
            chk("rsp_id", rsp_id, e_id);
            chk("rsp_sum", rsp_sum, e_sum);
            chk("cfg_busy", cfg_busy, m_drain);
        end
        if (m_known) chk("add_k", add_k, m_k);
        pre_infl = infl.size();
        @(posedge clk);
        if (rst) begin
            infl.delete(); mfifo.delete();
            m_drain = 0; m_k = 0; m_pend = 0; m_ptr = NREQ - 1; m_known = 1; n_issue = 0;
        end else begin
            if (pop) void'(mfifo.pop_front());
            foreach (infl[i]) begin
                t = infl[i];
                t.age++;
                if (t.age == LAT) begin
                    e.id = t.id; e.sum = t.sum;
                    mfifo.push_back(e);
                end else nq.push_back(t);
            end
            infl = nq;
            if (cfg_we) begin
                m_pend = int'(cfg_k); m_drain = 1;
            end else if (m_drain && pre_infl == 0) begin
                m_k = m_pend; m_drain = 0;
            end
            if (g >= 0) begin
                t.id = g; t.sum = modf(int'(ra[g]), int'(rb[g]), m_k); t.age = 0;
                infl.push_back(t);
                m_ptr = g;
                n_issue++;
            end
        end
        #1;
    endtask

    typedef struct {
        logic [NREQ-1:0] vmask;
        logic            rr;
        logic [NREQ-1:0] e_ready;
        logic            e_rv;
        int              e_id;
    } vec_t;
    vec_t tbl[8];

    initial begin
        int first, nresp, nissue, seen_busy;
        int ids[3];
        checks = 0; errors = 0; m_known = 0; n_issue = 0;
        m_drain = 0; m_k = 0; m_pend = 0; m_ptr = NREQ - 1;

        // Streaming from reset: grants 0,1,2,3,0,... and rsp_id trails by LAT+1 cycles.
        tbl[0] = '{4'hF, 1'b1, 4'b0001, 1'b0, 0};
        tbl[1] = '{4'hF, 1'b1, 4'b0010, 1'b0, 0};
        tbl[2] = '{4'hF, 1'b1, 4'b0100, 1'b0, 0};
        tbl[3] = '{4'hF, 1'b1, 4'b1000, 1'b1, 0};
        tbl[4] = '{4'hF, 1'b1, 4'b0001, 1'b1, 1};
        tbl[5] = '{4'hF, 1'b1, 4'b0010, 1'b1, 2};
        tbl[6] = '{4'hF, 1'b1, 4'b0100, 1'b1, 3};
        tbl[7] = '{4'hF, 1'b1, 4'b1000, 1'b1, 0};

        rst = 1'b1; req_valid = '0; rsp_ready = 1'b0; cfg_we = 1'b0; cfg_k = '0;
        for (int i = 0; i < NREQ; i++) begin ra[i] = N'(10 * i + 1); rb[i] = N'(i + 2); end
        #1;
        cycle(); cycle();
        rst = 1'b0;

        for (int i = 0; i < 8; i++) begin
            req_valid = tbl[i].vmask; rsp_ready = tbl[i].rr;
            cycle();
            chk("tbl_ready", o_ready, tbl[i].e_ready);
            chk("tbl_rsp_valid", o_rv, tbl[i].e_rv);
            if (tbl[i].e_rv) chk("tbl_rsp_id", o_id, tbl[i].e_id);
        end
        req_valid = '0;
        repeat (6) cycle();

        // Single op: 3+4 -> 7 from requester 2, first visible LAT+1 cycles after issue.
        ra[2] = 7'd3; rb[2] = 7'd4; req_valid = 4'b0100;
        cycle();
        chk("single_issue", o_ready, 4'b0100);
        req_valid = '0;
        first = -1;
        for (int i = 1; i <= 8; i++) begin
            cycle();
            if (o_rv && first < 0) begin
                first = i;
                chk("single_sum", o_sum, 7);
                chk("single_id", o_id, 2);
            end
        end
        chk("single_latency", first, LAT + 1);

        // Backpressure: credit admits exactly LAT+1 issues, then drain in order.
        rsp_ready = 1'b0; req_valid = 4'hF; nissue = 0;
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (o_ready != 0) nissue++;
        end
        chk("bp_issues", nissue, 3);
        chk("bp_stalled", o_ready, 0);
        rsp_ready = 1'b1; req_valid = '0;
        for (int i = 0; i < 3; i++) begin
            cycle();
            chk("bp_rsp_valid", o_rv, 1);
            ids[i] = int'(o_id);
        end
        chk("bp_order0", ids[0], 3);
        chk("bp_order1", ids[1], 0);
        chk("bp_order2", ids[2], 1);
        req_valid = 4'hF;
        cycle();
        chk("bp_resume", o_ready != 0, 1);
        req_valid = '0;
        repeat (6) cycle();

        // Modulus update with two ops in flight.
        req_valid = 4'b0001; nresp = 0;
        cycle(); if (o_rv) nresp++;
        cycle(); if (o_rv) nresp++;
        cfg_we = 1'b1; cfg_k = 7'd5;
        cycle(); if (o_rv) nresp++;
        chk("cfg_no_issue", o_ready, 0);
        cfg_we = 1'b0; req_valid = '0; seen_busy = 0;
        for (int i = 0; i < 20; i++) begin
            cycle();
            if (o_rv) nresp++;
            if (o_busy) seen_busy = 1;
            if (!o_busy) break;
        end
        chk("cfg_busy_seen", seen_busy, 1);
        chk("cfg_busy_clear", o_busy, 0);
        chk("cfg_new_k", o_k, 5);
        repeat (4) begin cycle(); if (o_rv) nresp++; end
        chk("cfg_old_results", nresp, 2);
        req_valid = 4'b0001;
        cycle();
        chk("cfg_resume", o_ready, 4'b0001);
        req_valid = '0;
        repeat (6) cycle();

        // Reset mid-operation with results buffered and in flight.
        rsp_ready = 1'b0; req_valid = 4'hF;
        repeat (4) cycle();
        rst = 1'b1;
        cycle();
        rst = 1'b0; rsp_ready = 1'b1;
        cycle();
        chk("rst_mid_rsp_valid", o_rv, 0);
        chk("rst_mid_grant0", o_ready, 4'b0001);
        req_valid = '0;
        repeat (5) cycle();

        // Random traffic against the model.
        for (int c = 0; c < 600; c++) begin
            req_valid = NREQ'($urandom);
            for (int i = 0; i < NREQ; i++) begin ra[i] = N'($urandom); rb[i] = N'($urandom); end
            rsp_ready = ($urandom_range(0, 9) < 7);
            cfg_we = ($urandom_range(0, 24) == 0);
            cfg_k = N'($urandom_range(0, 20));
            rst = ($urandom_range(0, 79) == 0);
            cycle();
        end
        rst = 1'b0; cfg_we = 1'b0; req_valid = '0; rsp_ready = 1'b1;
        repeat (8) cycle();

`ifdef MODADD_SCHED_STATS_EN
        chk("op_cnt", op_cnt, n_issue % 65536);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
